// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with x0 hardwired to zero and a hardware clear sequencer.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                clr_req,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic                busy
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [AW-1:0]     ctr;
  logic [AW-1:0]     ctr_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              wr_user;
  logic [XLEN-1:0]   mem [NREGS];

  assign busy = (state == CLEAR);

  // An accepted user write: used both for the array and the bypass.
  assign wr_user = rst
                && (state == IDLE)
                && !clr_req
                && we
                && (waddr != '0);

  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = wdata;
    if (!rst) begin
      state_n = CLEAR;
      ctr_n   = AW'(1);
    end else if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = ctr;
      wr_data = '0;
      ctr_n   = ctr + AW'(1);
      if (ctr == AW'(NREGS - 1)) begin
        state_n = IDLE;
      end
    end else if (clr_req) begin
      state_n = CLEAR;
      ctr_n   = AW'(1);
    end else begin
      wr_en = wr_user;
    end
  end

  always_ff @(posedge clk) begin
    state <= state_n;
    ctr   <= ctr_n;
  end

  // Entry 0 is never written; reads of x0 are forced to zero below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = raddr[i*AW +: AW];

    always_comb begin
      rd = '0;
      if (!busy && (ra != '0)) begin
        rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_user && (ra == waddr)) begin
          rd = wdata;
        end
`endif
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array model.
// Checks the default build and a 64-bit, 16-register, 3-port instance.
module tb_regfile_mp;

  localparam int N  = 32;
  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        clr_req = 1'b0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic        busy;

  logic         we_b = 1'b0;
  logic [3:0]   waddr_b = '0;
  logic [63:0]  wdata_b = '0;
  logic         clr_b = 1'b0;
  logic [11:0]  raddr_b = '0;
  logic [191:0] rdata_b;
  logic         busy_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [31:0] m [N];
  int          cnt = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .clr_req(clr_req), .raddr(raddr), .rdata(rdata), .busy(busy)
  );

  regfile_mp #(.XLEN(64), .NREGS(NB), .NRD(3)) dut_b (
    .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b),
    .wdata(wdata_b), .clr_req(clr_b), .raddr(raddr_b),
    .rdata(rdata_b), .busy(busy_b)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a clear makes the whole file read zero and blocks for N-1 edges.
  always @(posedge clk) begin
    if (!rst) begin
      cnt <= N - 1;
      for (int i = 0; i < N; i++) m[i] <= '0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end else if (clr_req) begin
      cnt <= N - 1;
      for (int i = 0; i < N; i++) m[i] <= '0;
    end else if (we && waddr != 0) begin
      m[waddr] <= wdata;
    end
  end

  function automatic logic [31:0] exp_rd(input int p);
    logic [4:0] ra;
    ra = raddr[p*5 +: 5];
    if (cnt != 0 || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst && we && waddr != 0 && !clr_req && ra == waddr)
      return wdata;
`endif
    return m[ra];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'd0, busy}, {63'd0, cnt != 0});
      for (int p = 0; p < 2; p++)
        check("rdata", {32'd0, rdata[p*32 +: 32]},
              {32'd0, exp_rd(p)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic busy_len(input string nm, input int want);
    int n = 0;
    while (busy && n < 100) begin
      raddr = 10'($urandom);
      #1;
      check({nm, "_rd0"}, {32'd0, rdata[31:0]}, 64'd0);
      if (n == 5) clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      n++;
    end
    check(nm, 64'(n), 64'(want));
  endtask

  task automatic all_zero(input string nm);
    for (int a = 0; a < N; a++) begin
      raddr = {5'(N - 1 - a), 5'(a)};
      #1;
      check(nm, rdata, 64'd0);
      step();
    end
  endtask

  initial begin
    int na;
    int nb;
    step();
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b1;
    na = 0;
    nb = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (!busy && na == 0) na = n;
      if (!busy_b && nb == 0) nb = n;
    end
    check("rst_busy_len", 64'(na), 64'd31);
    check("rst_busy_len_b", 64'(nb), 64'd15);
    all_zero("rst_zero");

    we_b = 1'b1;
    waddr_b = 4'd1; wdata_b = 64'h0123_4567_89AB_CDEF; step();
    waddr_b = 4'd2; wdata_b = 64'hFEDC_BA98_7654_3210; step();
    waddr_b = 4'd15; wdata_b = 64'hCAFE_F00D_1234_5678; step();
    we_b = 1'b0;
    raddr_b = {4'd15, 4'd2, 4'd1};
    #1;
    check("b_p0", rdata_b[0 +: 64], 64'h0123_4567_89AB_CDEF);
    check("b_p1", rdata_b[64 +: 64], 64'hFEDC_BA98_7654_3210);
    check("b_p2", rdata_b[128 +: 64], 64'hCAFE_F00D_1234_5678);
    step();

    wr(5'd5, 32'hDEADBEEF);
    raddr = {5'd5, 5'd5};
    #1;
    check("x5_p0", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
    check("x5_p1", {32'd0, rdata[63:32]}, 64'hDEADBEEF);
    wr(5'd0, 32'h12345678);
    raddr = '0;
    #1;
    check("x0", rdata, 64'd0);

    wr(5'd7, 32'h1);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    raddr = {5'd7, 5'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same", {32'd0, rdata[31:0]}, 64'hA5A5A5A5);
`else
    check("byp_same", {32'd0, rdata[31:0]}, 64'h1);
`endif
    step();
    we = 1'b0;
    check("byp_after", {32'd0, rdata[31:0]}, 64'hA5A5A5A5);

    for (int a = 1; a < N; a++) wr(5'(a), 32'(a));
    raddr = {5'd31, 5'd3};
    #1;
    check("fill", rdata, {32'd31, 32'd3});
    clr_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
    step();
    clr_req = 1'b0; we = 1'b0;
    busy_len("clr_busy_len", 31);
    all_zero("clr_zero");

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    busy_len("rst_mid_len", 31);
    all_zero("rst_mid_zero");

    for (int c = 0; c < 800; c++) begin
      we = 1'($urandom);
      waddr = 5'($urandom);
      wdata = $urandom;
      raddr = ($urandom_range(0, 3) == 0) ? {waddr, waddr}
                                           : 10'($urandom);
      clr_req = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1; we = 1'b0; clr_req = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RISC-V single-cycle core; it replaces the fixed 32x32, two-read-port register file. x0 is hardwired to zero. A hardware clear sequencer zeroes every register after reset or on request, with a `busy` indication. An optional write-to-read bypass is available. Reads feed the decode/ALU operand path; the write port is driven by the writeback mux.

## Interface
- `XLEN`, 32, register width in bits.
- `NREGS`, 32, number of architectural registers; power of two, >= 4.
- `NRD`, 2, number of read ports, 1..4.
- `AW`, $clog2(NREGS), address width; derived, not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `we`  in  1  write enable.
- `waddr`  in  AW  write address.
- `wdata`  in  XLEN  write data.
- `clr_req`  in  1  single-cycle request to zero the whole file.
- `raddr`  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW].
- `rdata`  out  NRD*XLEN  packed read data; port i is bits [i*XLEN +: XLEN].
- `busy`  out  1  clear sequence in progress; writes are ignored and reads return 0.

## Operation
- Storage is an array `NREGS` x `XLEN`. Register 0 has no storage bit that is ever written and always reads 0.
- The FSM has two states: `IDLE` and `CLEAR`. A clear counter `ctr` is AW bits wide.
- `rst` low at a posedge:
  - state <= `CLEAR`, `ctr` <= 1.
  - No array write occurs.
  - Array contents are otherwise not reset.
- `CLEAR` with `rst` high, at each posedge:
  - Registers[`ctr`] <= 0.
  - `ctr` <= `ctr`+1.
  - If `ctr` == `NREGS`-1, state <= `IDLE`.
  - `we` and `clr_req` are ignored.
- `IDLE`, in priority order:
  - `clr_req`=1: state <= `CLEAR`, `ctr` <= 1. A `we` in the same cycle is dropped.
  - Otherwise `we`=1 and `waddr`!=0: Registers[`waddr`] <= `wdata`.
  - `we` with `waddr`=0 has no effect.
- Reads are combinational per port:
  - `busy`=1 gives 0.
  - `raddr`=0 gives 0.
  - Otherwise the result is Registers[raddr], subject to the bypass rule in Configuration.
- Multiple ports may read the same address in the same cycle; each returns the identical value.
- `busy` = (state == `CLEAR`), decoded from the registered state with no combinational path from inputs.

## Timing
- Reset values:
  - state = `CLEAR` and `busy` = 1 while `rst` is low and for `NREGS`-1 posedges after release.
  - `rdata` = 0 on all ports throughout that interval.
- Clear latency is `NREGS`-1 cycles for both reset release and `clr_req`.
  - With `NREGS`=32, `busy` falls after the 31st posedge following the first posedge with `rst`=1.
- Write latency is 1 edge. Data written at edge N is readable after edge N (combinational read) without bypass.
- Read latency is 0 cycles (asynchronous read).
- `rst` asserted mid-CLEAR restarts the sequence at `ctr`=1.
- `clr_req` while `busy` is ignored and does not extend the sequence.
- Counter wrap: `ctr` reaches `NREGS`-1 and the FSM leaves `CLEAR` at that edge. The `ctr` value is don't-care in `IDLE`.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: in `IDLE`, a read port whose `raddr` equals `waddr` with `we`=1, `waddr`!=0 and `clr_req`=0 returns `wdata` in the same cycle (write-first).
- Not defined: that read returns the old register contents until the write edge (read-first).
- `busy` and x0 rules hold in both builds.

## Test plan
- Reset with `NREGS`=32:
  - Hold `rst`=0 for 3 cycles, then release.
  - Require `busy`=1 for exactly 31 posedges after release, then 0.
  - Afterwards, every address reads 0x00000000.
- Write/read:
  - Write 0xDEADBEEF to x5.
  - Next cycle, `raddr` port0=5 and port1=5 both give 0xDEADBEEF.
  - Write 0x12345678 to x0; a read of x0 gives 0.
- Bypass:
  - `we`=1, `waddr`=7, `wdata`=0xA5A5A5A5, `raddr` port0=7, with x7 previously 0x1.
  - With `REGFILE_BYPASS_EN`, same-cycle read gives 0xA5A5A5A5.
  - Without it, same-cycle read gives 0x00000001; the read after the edge gives 0xA5A5A5A5.
- `clr_req` with simultaneous `we`:
  - Fill x1..x31 with their own index.
  - Pulse `clr_req` together with `we` to x3 = 0xFF.
  - Require `busy` for 31 cycles, all reads 0 during the sequence, and all registers 0 after; the x3 write is dropped.
- Reset mid-clear:
  - Pulse `clr_req`, then after 10 cycles drive `rst`=0 for 1 cycle.
  - Require `busy` to persist 31 cycles after release, with all registers 0 at the end.
- Parameter sweep:
  - `XLEN`=64, `NREGS`=16, `NRD`=3.
  - Clear takes 15 cycles.
  - Three ports reading x1, x2, x15 return the written 64-bit values independently.
